// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer interface: time/alarm inputs, user pulses and status outputs.
// master drives time and controls; slave is the sequencer itself.
interface alarm_sequencer_if;
  logic       i_sec_tick;
  logic [4:0] i_cur_hour;
  logic [5:0] i_cur_min;
  logic [5:0] i_cur_sec;
  logic [4:0] i_alm_hour;
  logic [5:0] i_alm_min;
  logic [5:0] i_alm_sec;
  logic       i_alarm_en;
  logic       i_stop;
  logic       i_snooze;
  logic [1:0] o_state;
  logic       o_ringing;
  logic       o_buzz;

  modport master (
    output i_sec_tick,
    output i_cur_hour, i_cur_min, i_cur_sec,
    output i_alm_hour, i_alm_min, i_alm_sec,
    output i_alarm_en, i_stop, i_snooze,
    input  o_state, o_ringing, o_buzz
  );

  modport slave (
    input  i_sec_tick,
    input  i_cur_hour, i_cur_min, i_cur_sec,
    input  i_alm_hour, i_alm_min, i_alm_sec,
    input  i_alarm_en, i_stop, i_snooze,
    output o_state, o_ringing, o_buzz
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: IDLE/RING/SNOOZE FSM with gated square-wave buzzer.
// Define ALARM_SNOOZE_EN to build the snooze path; otherwise i_snooze is ignored.
module alarm_sequencer #(
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned TONE_HALF        = 25000
) (
  input logic              clk,
  input logic              rst,
  alarm_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef ALARM_SNOOZE_EN
    SNOOZE = 2'd2,
`endif
    RING   = 2'd1
  } state_t;

  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_SEC - 1);
  localparam logic [15:0] TONE_LAST = 16'(TONE_HALF - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0]  SNZ_LAST  = 10'(SNOOZE_SEC - 1);
`endif

  state_t      state, state_n;
  logic        match, match_d, trigger;
  logic [7:0]  ring_cnt, ring_n;
  logic        env, env_n;
  logic [15:0] tone_cnt, tone_cnt_n;
  logic        tone, tone_n;
  logic        buzz, buzz_n;
`ifdef ALARM_SNOOZE_EN
  logic [9:0]  snz_cnt, snz_n;
`else
  logic        unused_snooze;
  assign unused_snooze = bus.i_snooze;
`endif

  assign match = bus.i_alarm_en
               & (bus.i_cur_hour == bus.i_alm_hour)
               & (bus.i_cur_min  == bus.i_alm_min)
               & (bus.i_cur_sec  == bus.i_alm_sec);

  assign trigger = match & ~match_d;

  // Edge detector on the match; resets high so an equal time at release is not a trigger.
  always_ff @(posedge clk) begin
    if (rst) match_d <= 1'b1;
    else     match_d <= match;
  end

  // Next state, ring/snooze second counters and envelope.
  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    env_n   = env;
`ifdef ALARM_SNOOZE_EN
    snz_n   = snz_cnt;
`endif
    unique case (state)
      IDLE: begin
        ring_n = '0;
        env_n  = 1'b0;
        if (trigger) begin
          state_n = RING;
          env_n   = 1'b1;
        end
      end
      RING: begin
        if (!bus.i_alarm_en || bus.i_stop) begin
          state_n = IDLE;
          ring_n  = '0;
          env_n   = 1'b0;
        end else if (bus.i_sec_tick && ring_cnt == RING_LAST) begin
          state_n = IDLE;
          ring_n  = '0;
          env_n   = 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (bus.i_snooze) begin
          state_n = SNOOZE;
          ring_n  = '0;
          env_n   = 1'b0;
          snz_n   = '0;
        end
`endif
        else if (bus.i_sec_tick) begin
          ring_n = ring_cnt + 8'd1;
          env_n  = ~env;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!bus.i_alarm_en || bus.i_stop) begin
          state_n = IDLE;
          snz_n   = '0;
        end else if (bus.i_sec_tick && snz_cnt == SNZ_LAST) begin
          state_n = RING;
          ring_n  = '0;
          env_n   = 1'b1;
          snz_n   = '0;
        end else if (bus.i_sec_tick) begin
          snz_n = snz_cnt + 10'd1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        ring_n  = '0;
        env_n   = 1'b0;
      end
    endcase
  end

  // Tone generator runs only while staying in RING; buzz is gated by the next state.
  always_comb begin
    tone_cnt_n = '0;
    tone_n     = 1'b0;
    if (state == RING && state_n == RING) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt_n = '0;
        tone_n     = ~tone;
      end else begin
        tone_cnt_n = tone_cnt + 16'd1;
        tone_n     = tone;
      end
    end
    buzz_n = (state_n == RING) & tone_n & env_n;
  end

  // State, counters and registered buzzer output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ring_cnt <= '0;
      env      <= 1'b0;
      tone_cnt <= '0;
      tone     <= 1'b0;
      buzz     <= 1'b0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_n;
      env      <= env_n;
      tone_cnt <= tone_cnt_n;
      tone     <= tone_n;
      buzz     <= buzz_n;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze second counter.
  always_ff @(posedge clk) begin
    if (rst) snz_cnt <= '0;
    else     snz_cnt <= snz_n;
  end
`endif

  assign bus.o_state   = state;
  assign bus.o_ringing = (state == RING);
  assign bus.o_buzz    = buzz;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer (RING 3 s, SNOOZE 2 s, tone half 4 clk).
// Snooze checks follow ALARM_SNOOZE_EN as defined for the build.
module tb_alarm_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alarm_sequencer_if bus();

  alarm_sequencer #(
    .RING_TIMEOUT_SEC(3),
    .SNOOZE_SEC(2),
    .TONE_HALF(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // 19 quiet cycles then a one-clk tick: one second every 20 clk.
  task automatic sec();
    run(19);
    bus.i_sec_tick = 1'b1;
    step();
    bus.i_sec_tick = 1'b0;
  endtask

  // Leave and re-enter 07:30:00 to start a fresh match episode.
  task automatic trig(input string tag);
    bus.i_cur_sec = 6'd1;
    step();
    bus.i_cur_sec = 6'd0;
    step();
    chk(tag, int'(bus.o_state), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_sec_tick = 1'b0;
    bus.i_alm_hour = 5'd7;
    bus.i_alm_min  = 6'd30;
    bus.i_alm_sec  = 6'd0;
    bus.i_cur_hour = 5'd7;
    bus.i_cur_min  = 6'd29;
    bus.i_cur_sec  = 6'd59;
    bus.i_alarm_en = 1'b1;
    bus.i_stop     = 1'b0;
    bus.i_snooze   = 1'b0;

    step();
    chk("rst_state", int'(bus.o_state), 0);
    chk("rst_ring", int'(bus.o_ringing), 0);
    chk("rst_buzz", int'(bus.o_buzz), 0);
    rst = 1'b0;
    run(2);
    chk("idle_pre", int'(bus.o_state), 0);

    // 07:29:59 -> 07:30:00: ringing one clk later, tone half-period 4 clk.
    bus.i_cur_min = 6'd30;
    bus.i_cur_sec = 6'd0;
    step();
    chk("ring_entry", int'(bus.o_ringing), 1);
    chk("ring_state", int'(bus.o_state), 1);
    chk("buzz_e0", int'(bus.o_buzz), 0);
    run(3);
    chk("buzz_e3", int'(bus.o_buzz), 0);
    step();
    chk("buzz_e4", int'(bus.o_buzz), 1);
    run(3);
    chk("buzz_e7", int'(bus.o_buzz), 1);
    step();
    chk("buzz_e8", int'(bus.o_buzz), 0);
    run(4);
    chk("buzz_e12", int'(bus.o_buzz), 1);

    // Timeout on the 3rd tick; envelope off after the 1st.
    sec();
    chk("to_t1", int'(bus.o_state), 1);
    run(4);
    chk("env_off", int'(bus.o_buzz), 0);
    sec();
    chk("to_t2", int'(bus.o_state), 1);
    sec();
    chk("to_t3", int'(bus.o_state), 0);
    chk("to_buzz", int'(bus.o_buzz), 0);
    run(10);
    chk("no_retrig", int'(bus.o_state), 0);

`ifdef ALARM_SNOOZE_EN
    trig("trig_snz");
    run(2);
    bus.i_snooze = 1'b1;
    step();
    bus.i_snooze = 1'b0;
    chk("snz_state", int'(bus.o_state), 2);
    chk("snz_buzz", int'(bus.o_buzz), 0);
    chk("snz_ring", int'(bus.o_ringing), 0);
    sec();
    chk("snz_t1", int'(bus.o_state), 2);
    sec();
    chk("snz_t2", int'(bus.o_state), 1);
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    chk("snz_stop", int'(bus.o_state), 0);
`else
    trig("trig_nosnz");
    run(2);
    bus.i_snooze = 1'b1;
    step();
    bus.i_snooze = 1'b0;
    chk("nosnz_state", int'(bus.o_state), 1);
    sec();
    chk("nosnz_t1", int'(bus.o_state), 1);
    sec();
    chk("nosnz_t2", int'(bus.o_state), 1);
    sec();
    chk("nosnz_t3", int'(bus.o_state), 0);
`endif

    // Stop and snooze in the same clk: stop wins.
    trig("trig_both");
    run(3);
    bus.i_stop   = 1'b1;
    bus.i_snooze = 1'b1;
    step();
    bus.i_stop   = 1'b0;
    bus.i_snooze = 1'b0;
    chk("both_state", int'(bus.o_state), 0);

    // Disarming forces IDLE.
    trig("trig_en");
    bus.i_alarm_en = 1'b0;
    step();
    chk("en_off", int'(bus.o_state), 0);
    bus.i_cur_sec  = 6'd5;
    bus.i_alarm_en = 1'b1;
    step();
    chk("en_back", int'(bus.o_state), 0);

    // Reset mid-ring with buzzer on; time still equal at release.
    trig("trig_rst");
    run(4);
    chk("pre_rst_buzz", int'(bus.o_buzz), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_state", int'(bus.o_state), 0);
    chk("mid_rst_buzz", int'(bus.o_buzz), 0);
    rst = 1'b0;
    run(5);
    chk("post_rst_idle", int'(bus.o_state), 0);
    chk("post_rst_buzz", int'(bus.o_buzz), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
